// File: rtl/checkpoint_pkg.sv
// Shared types for the checkpoint sequence monitor.
//   state_e    : run state of the monitor FSM
//   FC_*       : encodings reported on fail_code
package checkpoint_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DONE_PASS,
    ST_DONE_FAIL,
    ST_DONE_TMO
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_CFG      = 2'd2;
  localparam logic [1:0] FC_TMO      = 2'd3;

endpackage

// File: rtl/checkbits_settle.sv
// Input conditioning for the monitored status bus.
// A 2-flop synchronizer brings checkbits into the clock domain. A hold
// counter tracks how long the synchronized value has been unchanged. When it
// reaches STABLE_CYCLES, the value counts as settled.
//
// Ports:
//   clock, resetb : clock and asynchronous active-low reset
//   checkbits     : raw bus, asynchronous to clock
//   value         : synchronized bus (valid as the settled value when settle_evt)
//   settle_evt    : one-cycle pulse when a value different from the previously
//                   settled one has held for STABLE_CYCLES cycles
//   is_settled    : the current synchronized value has held >= STABLE_CYCLES
module checkbits_settle #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] checkbits,
  output logic [WIDTH-1:0] value,
  output logic             settle_evt,
  output logic             is_settled
);

  // The counter saturates one above STABLE_CYCLES, so the equality test that
  // fires settle_evt can only be true once per run of an unchanged value.
  localparam int CW = $clog2(STABLE_CYCLES + 2);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t STABLE_L = cnt_t'(STABLE_CYCLES);
  localparam cnt_t SAT_L    = cnt_t'(STABLE_CYCLES + 1);

  logic [WIDTH-1:0] sync1_q, sync2_q, last_q;
  logic [WIDTH-1:0] settled_q, settled_d;
  cnt_t             hold_q, hold_d;

  // hold_d is the number of cycles the current value has held, counting this one.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    hold_d     = hold_q;
    settled_d  = settled_q;
    settle_evt = 1'b0;
    if (sync2_q != last_q) begin
      hold_d = cnt_t'(1);
    end else if (hold_q != SAT_L) begin
      hold_d = hold_q + cnt_t'(1);
    end
    if (hold_d == STABLE_L) begin
      settled_d = sync2_q;
      // A glitch that returns to the last settled value is not a new event.
      settle_evt = (sync2_q != settled_q);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      last_q    <= '0;
      settled_q <= '0;
      hold_q    <= '0;
    end else begin
      sync1_q   <= checkbits;
      sync2_q   <= sync1_q;
      last_q    <= sync2_q;
      settled_q <= settled_d;
      hold_q    <= hold_d;
    end
  end

  assign value      = sync2_q;
  assign is_settled = (hold_d >= STABLE_L);

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Checkpoint sequence monitor: watches a firmware-driven status bus for an
// ordered list of up to DEPTH expected codes. It reports progress and the
// result in registers that LA or housekeeping can read.
//
// Ports:
//   clock, resetb   : clock and asynchronous active-low reset
//   checkbits       : monitored bus (asynchronous)
//   wr_en/idx/data  : expected-code table write port (ignored while ARMED)
//   num_stages      : codes in the sequence (1..DEPTH)
//   strict          : 1 = an unexpected settled code fails the run
//   timeout_cycles  : per-stage timeout, 0 = disabled
//   start, clear    : arm pulse / return-to-IDLE pulse (clear wins)
//   busy            : run in progress
//   started, pass, fail, timeout : run status flags
//   stage           : codes matched so far
//   fail_value      : settled value that caused a mismatch
//   fail_code       : FC_NONE / FC_MISMATCH / FC_CFG / FC_TMO
module checkpoint_seq_monitor
  import checkpoint_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int TMO_W         = 24,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] checkbits,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [SW-1:0]    num_stages,
  input  logic             strict,
  input  logic [TMO_W-1:0] timeout_cycles,
  input  logic             start,
  input  logic             clear,
  output logic             busy,
  output logic             started,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [SW-1:0]    stage,
  output logic [WIDTH-1:0] fail_value,
  output logic [1:0]       fail_code
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q [DEPTH];
  logic [WIDTH-1:0] exp_d [DEPTH];
  logic [SW-1:0]    stage_q, stage_d, num_q, num_d;
  logic             strict_q, strict_d, first_q, first_d;
  logic [TMO_W-1:0] tmo_lim_q, tmo_lim_d, timer_q, timer_d;
  logic             started_q, started_d, pass_q, pass_d;
  logic             fail_q, fail_d, timeout_q, timeout_d;
  logic [WIDTH-1:0] fail_value_q, fail_value_d;
  logic [1:0]       fail_code_q, fail_code_d;

  logic [WIDTH-1:0] s_value;
  logic             settle_evt, is_settled;

  checkbits_settle #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_settle (
    .clock     (clock),
    .resetb    (resetb),
    .checkbits (checkbits),
    .value     (s_value),
    .settle_evt(settle_evt),
    .is_settled(is_settled)
  );

  logic             cfg_ok, evaluate, hit, again;
  logic [WIDTH-1:0] exp_cur, exp_prev;
  logic [SW-1:0]    stage_inc;
  logic [TMO_W-1:0] timer_inc;

  assign cfg_ok    = (num_stages != '0) && (int'(num_stages) <= DEPTH);
  assign exp_cur   = exp_q[IW'(stage_q)];
  assign exp_prev  = exp_q[IW'(stage_q - SW'(1))];
  assign stage_inc = stage_q + SW'(1);
  assign timer_inc = timer_q + TMO_W'(1);
  // In the first ARMED cycle a value that settled before arming is also
  // evaluated, but only a match against exp[0] has any effect.
  assign evaluate  = settle_evt || (first_q && is_settled);
  assign hit       = evaluate && (s_value == exp_cur);
  // Re-settling on the code just matched (e.g. after a glitch) is harmless.
  assign again     = (stage_q != '0) && (s_value == exp_prev);

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    stage_d      = stage_q;
    num_d        = num_q;
    strict_d     = strict_q;
    first_d      = 1'b0;
    tmo_lim_d    = tmo_lim_q;
    timer_d      = timer_q;
    started_d    = started_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;
    fail_value_d = fail_value_q;
    fail_code_d  = fail_code_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (state_q != ST_ARMED) && (wr_idx == IW'(i))) begin
        exp_d[i] = wr_data;
      end
    end

    if (clear || (start && state_q != ST_ARMED)) begin
      stage_d      = '0;
      timer_d      = '0;
      started_d    = 1'b0;
      pass_d       = 1'b0;
      fail_d       = 1'b0;
      timeout_d    = 1'b0;
      fail_value_d = '0;
      fail_code_d  = FC_NONE;
    end

    if (clear) begin
      state_d = ST_IDLE;
    end else if (start && state_q != ST_ARMED) begin
      if (cfg_ok) begin
        state_d   = ST_ARMED;
        num_d     = num_stages;
        strict_d  = strict;
        tmo_lim_d = timeout_cycles;
        first_d   = 1'b1;
      end else begin
        state_d     = ST_DONE_FAIL;
        fail_d      = 1'b1;
        fail_code_d = FC_CFG;
      end
    end else if (state_q == ST_ARMED) begin
      // Priority: match, then strict mismatch, then timer expiry.
      if (hit) begin
        stage_d = stage_inc;
        timer_d = '0;
        if (stage_q == '0) started_d = 1'b1;
        if (stage_inc == num_q) begin
          state_d = ST_DONE_PASS;
          pass_d  = 1'b1;
        end
      end else if (settle_evt && !again && strict_q) begin
        state_d      = ST_DONE_FAIL;
        fail_d       = 1'b1;
        fail_code_d  = FC_MISMATCH;
        fail_value_d = s_value;
      end else if ((tmo_lim_q != '0) && (timer_inc == tmo_lim_q)) begin
        state_d     = ST_DONE_TMO;
        timeout_d   = 1'b1;
        fail_code_d = FC_TMO;
        timer_d     = timer_inc;
      end else begin
        timer_d = timer_inc;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_IDLE;
      // NOTE: the code table is small and must read back as zero after reset,
      // so it is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) exp_q[i] <= '0;
      stage_q      <= '0;
      num_q        <= '0;
      strict_q     <= 1'b0;
      first_q      <= 1'b0;
      tmo_lim_q    <= '0;
      timer_q      <= '0;
      started_q    <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fail_value_q <= '0;
      fail_code_q  <= FC_NONE;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      stage_q      <= stage_d;
      num_q        <= num_d;
      strict_q     <= strict_d;
      first_q      <= first_d;
      tmo_lim_q    <= tmo_lim_d;
      timer_q      <= timer_d;
      started_q    <= started_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      fail_value_q <= fail_value_d;
      fail_code_q  <= fail_code_d;
    end
  end

  assign busy       = (state_q == ST_ARMED);
  assign started    = started_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign stage      = stage_q;
  assign fail_value = fail_value_q;
  assign fail_code  = fail_code_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Self-checking bench for checkpoint_seq_monitor (WIDTH=16, DEPTH=4,
// STABLE_CYCLES=2, TMO_W=24). Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, away from the active edge.
module tb_checkpoint_seq_monitor;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic [15:0] checkbits = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_idx = '0;
  logic [15:0] wr_data = '0;
  logic [2:0]  num_stages = '0;
  logic        strict = 1'b0;
  logic [23:0] timeout_cycles = '0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        busy, started, pass, fail, timeout;
  logic [2:0]  stage;
  logic [15:0] fail_value;
  logic [1:0]  fail_code;

  checkpoint_seq_monitor #(
    .WIDTH(16), .DEPTH(4), .STABLE_CYCLES(2), .TMO_W(24)
  ) dut (
    .clock(clock), .resetb(resetb), .checkbits(checkbits),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .num_stages(num_stages), .strict(strict), .timeout_cycles(timeout_cycles),
    .start(start), .clear(clear), .busy(busy), .started(started),
    .pass(pass), .fail(fail), .timeout(timeout), .stage(stage),
    .fail_value(fail_value), .fail_code(fail_code)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        busy;
    logic        started;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [2:0]  stage;
    logic [1:0]  fail_code;
    logic [15:0] fail_value;
  } status_t;

  typedef struct {
    logic [15:0] code;
    int          hold;
    status_t     exp;
  } vec_t;

  vec_t    vecs[$];
  status_t sb[$];
  int      n_checks = 0;
  int      n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic status_t st(input logic b, input logic s, input logic p,
                                 input logic f, input logic t, input logic [2:0] stg,
                                 input logic [1:0] fc, input logic [15:0] fv);
    status_t r;
    r.busy = b; r.started = s; r.pass = p; r.fail = f; r.timeout = t;
    r.stage = stg; r.fail_code = fc; r.fail_value = fv;
    return r;
  endfunction

  function automatic vec_t v(input logic [15:0] code, input int hold, input status_t e);
    vec_t r;
    r.code = code; r.hold = hold; r.exp = e;
    return r;
  endfunction

  task automatic check_status(input string label, input status_t e);
    check({label, ".busy"},       32'(busy),       32'(e.busy));
    check({label, ".started"},    32'(started),    32'(e.started));
    check({label, ".pass"},       32'(pass),       32'(e.pass));
    check({label, ".fail"},       32'(fail),       32'(e.fail));
    check({label, ".timeout"},    32'(timeout),    32'(e.timeout));
    check({label, ".stage"},      32'(stage),      32'(e.stage));
    check({label, ".fail_code"},  32'(fail_code),  32'(e.fail_code));
    check({label, ".fail_value"}, 32'(fail_value), 32'(e.fail_value));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [15:0] data);
    wr_en = 1'b1; wr_idx = idx; wr_data = data;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic arm(input logic [2:0] n, input logic s, input logic [23:0] t);
    num_stages = n; strict = s; timeout_cycles = t;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  // Drives each vector, queues its expected status, checks that nothing moves
  // one cycle early, then pops and compares at the 2+STABLE_CYCLES latency.
  task automatic run_vecs(input string label, input logic [2:0] prev_stage);
    status_t e;
    logic [2:0] prev;
    prev = prev_stage;
    for (int i = 0; i < vecs.size(); i++) begin
      checkbits = vecs[i].code;
      sb.push_back(vecs[i].exp);
      tick(3);
      check($sformatf("%s[%0d].early_stage", label, i), 32'(stage), 32'(prev));
      tick(1);
      e = sb.pop_front();
      check_status($sformatf("%s[%0d]", label, i), e);
      prev = e.stage;
      if (vecs[i].hold > 4) tick(vecs[i].hold - 4);
    end
    vecs.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    status_t z;
    z = st(0, 0, 0, 0, 0, 3'd0, 2'd0, 16'h0000);

    // Reset
    tick(3);
    check_status("reset_low", z);
    resetb = 1'b1;
    tick(2);
    check_status("reset_released", z);

    // Basic two-code pass with exact latency checks
    wr(2'd0, 16'hAB60);
    wr(2'd1, 16'hAB61);
    arm(3'd2, 1'b1, 24'd0);
    check_status("t1_armed", st(1, 0, 0, 0, 0, 3'd0, 2'd0, 16'h0));
    vecs.push_back(v(16'h0000, 10, st(1, 0, 0, 0, 0, 3'd0, 2'd0, 16'h0)));
    vecs.push_back(v(16'hAB60, 10, st(1, 1, 0, 0, 0, 3'd1, 2'd0, 16'h0)));
    vecs.push_back(v(16'hAB61, 10, st(0, 1, 1, 0, 0, 3'd2, 2'd0, 16'h0)));
    run_vecs("t1", 3'd0);

    // Glitch filtering
    do_clear();
    check_status("t2_clear", z);
    checkbits = 16'h0000; tick(8);
    arm(3'd2, 1'b1, 24'd0);
    tick(2);
    check_status("t2_armed", st(1, 0, 0, 0, 0, 3'd0, 2'd0, 16'h0));
    checkbits = 16'hAB60; tick(1); checkbits = 16'h0000; tick(10);
    check_status("t2_glitch_ab60", st(1, 0, 0, 0, 0, 3'd0, 2'd0, 16'h0));
    checkbits = 16'h1234; tick(1); checkbits = 16'h0000; tick(10);
    check_status("t2_glitch_1234", st(1, 0, 0, 0, 0, 3'd0, 2'd0, 16'h0));
    checkbits = 16'hAB60; tick(10);
    check_status("t2_held_ab60", st(1, 1, 0, 0, 0, 3'd1, 2'd0, 16'h0));

    // Strict mismatch, then the same stimulus in loose mode
    vecs.push_back(v(16'h5555, 10, st(0, 1, 0, 1, 0, 3'd1, 2'd1, 16'h5555)));
    run_vecs("t3_strict", 3'd1);
    do_clear();
    checkbits = 16'h0000; tick(8);
    arm(3'd2, 1'b0, 24'd0);
    checkbits = 16'hAB60; tick(8);
    checkbits = 16'h5555; tick(10);
    check_status("t3_loose", st(1, 1, 0, 0, 0, 3'd1, 2'd0, 16'h0));
    checkbits = 16'hAB61; tick(8);
    check_status("t3_loose_pass", st(0, 1, 1, 0, 0, 3'd2, 2'd0, 16'h0));

    // Timeout exactly 50 cycles after the AB60 match
    do_clear();
    checkbits = 16'h0000; tick(8);
    arm(3'd2, 1'b1, 24'd50);
    checkbits = 16'hAB60; tick(4);
    check_status("t4_match", st(1, 1, 0, 0, 0, 3'd1, 2'd0, 16'h0));
    tick(49);
    check_status("t4_before_tmo", st(1, 1, 0, 0, 0, 3'd1, 2'd0, 16'h0));
    tick(1);
    check_status("t4_tmo", st(0, 1, 0, 0, 1, 3'd1, 2'd3, 16'h0));

    // Match landing on the expiry cycle wins, and restarts the stage timer
    do_clear();
    checkbits = 16'h0000; tick(8);
    arm(3'd2, 1'b1, 24'd50);
    tick(46);
    checkbits = 16'hAB60; tick(3);
    check_status("t4b_pre", st(1, 0, 0, 0, 0, 3'd0, 2'd0, 16'h0));
    tick(1);
    check_status("t4b_match_on_expiry", st(1, 1, 0, 0, 0, 3'd1, 2'd0, 16'h0));
    tick(49);
    check_status("t4b_before_tmo", st(1, 1, 0, 0, 0, 3'd1, 2'd0, 16'h0));
    tick(1);
    check_status("t4b_tmo", st(0, 1, 0, 0, 1, 3'd1, 2'd3, 16'h0));

    // Value already settled at arm time matches exp[0]
    do_clear();
    arm(3'd2, 1'b1, 24'd0);
    tick(1);
    check_status("t4c_arm_time_match", st(1, 1, 0, 0, 0, 3'd1, 2'd0, 16'h0));

    // Configuration errors and control
    do_clear();
    arm(3'd0, 1'b1, 24'd0);
    check_status("t5_cfg_zero", st(0, 0, 0, 1, 0, 3'd0, 2'd2, 16'h0));
    tick(5);
    check_status("t5_cfg_hold", st(0, 0, 0, 1, 0, 3'd0, 2'd2, 16'h0));
    do_clear();
    check_status("t5_cleared", z);
    arm(3'd5, 1'b1, 24'd0);
    check_status("t5_cfg_big", st(0, 0, 0, 1, 0, 3'd0, 2'd2, 16'h0));
    do_clear();
    checkbits = 16'h0000; tick(8);
    arm(3'd2, 1'b0, 24'd0);
    wr(2'd0, 16'h1111);
    checkbits = 16'hAB60; tick(8);
    check_status("t5_wr_while_armed", st(1, 1, 0, 0, 0, 3'd1, 2'd0, 16'h0));
    arm(3'd0, 1'b1, 24'd0);
    check_status("t5_start_while_armed", st(1, 1, 0, 0, 0, 3'd1, 2'd0, 16'h0));
    num_stages = 3'd2; clear = 1'b1; start = 1'b1;
    tick(1);
    clear = 1'b0; start = 1'b0;
    check_status("t5_clear_and_start", z);
    tick(3);
    check("t5_idle_stays.busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-run
    checkbits = 16'h0000; tick(8);
    arm(3'd2, 1'b1, 24'd0);
    checkbits = 16'hAB60; tick(8);
    check("t6_pre_reset.stage", 32'(stage), 32'd1);
    #2 resetb = 1'b0;
    #1 check_status("t6_async_reset", z);
    tick(2);
    resetb = 1'b1;
    tick(8);
    // Table was cleared: exp[0] is now 0000, so settled AB60 does not match.
    arm(3'd1, 1'b0, 24'd0);
    tick(1);
    check_status("t6_table_cleared", st(1, 0, 0, 0, 0, 3'd0, 2'd0, 16'h0));
    checkbits = 16'h0000; tick(6);
    check_status("t6_zero_code_pass", st(0, 1, 1, 0, 0, 3'd1, 2'd0, 16'h0));

    // Re-program and run a four-stage sequence
    wr(2'd0, 16'h3001);
    wr(2'd1, 16'h3002);
    wr(2'd2, 16'h3003);
    wr(2'd3, 16'h3004);
    do_clear();
    arm(3'd4, 1'b1, 24'd0);
    vecs.push_back(v(16'h3001, 8, st(1, 1, 0, 0, 0, 3'd1, 2'd0, 16'h0)));
    vecs.push_back(v(16'h3002, 8, st(1, 1, 0, 0, 0, 3'd2, 2'd0, 16'h0)));
    vecs.push_back(v(16'h3003, 8, st(1, 1, 0, 0, 0, 3'd3, 2'd0, 16'h0)));
    vecs.push_back(v(16'h3004, 8, st(0, 1, 1, 0, 0, 3'd4, 2'd0, 16'h0)));
    run_vecs("t6_four", 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/checkpoint_seq_monitor.md
Name: checkpoint_seq_monitor

Overview:
Synthesizable, parametrised checkpoint monitor for the user project.
- Watches a WIDTH-bit status bus (e.g. mprj_io[31:16] driven by firmware) for an ordered sequence of up to DEPTH expected codes, such as 16'hAB60 then 16'hAB61.
- Reports started, pass, fail and timeout on-chip, so LA or housekeeping can read the result without a testbench.
- Generalises the single start/pass code pair into a programmable table, with glitch filtering, a per-stage timeout and a strict or loose mode.

Parameters:
- WIDTH, 16, width of the monitored bus and of each expected code.
- DEPTH, 4, number of entries in the expected-code table.
- STABLE_CYCLES, 2, cycles a synchronized value must hold before it counts as settled (>=1).
- TMO_W, 24, width of the timeout counter and of timeout_cycles.

Ports:
- clock  in  1  system clock.
- resetb  in  1  asynchronous active-low reset.
- checkbits  in  WIDTH  monitored bus; asynchronous to clock.
- wr_en  in  1  table write strobe.
- wr_idx  in  clog2(DEPTH)  table write index.
- wr_data  in  WIDTH  expected code to write.
- num_stages  in  clog2(DEPTH+1)  number of codes in the sequence.
- strict  in  1  1 = an unexpected settled code fails the run; 0 = ignore it.
- timeout_cycles  in  TMO_W  per-stage timeout; 0 disables the timeout.
- start  in  1  single-cycle arm pulse.
- clear  in  1  single-cycle return to IDLE.
- busy  out  1  high while ARMED.
- started  out  1  first code (index 0) matched in this run.
- pass  out  1  full sequence matched.
- fail  out  1  mismatch or bad configuration.
- timeout  out  1  stage timer expired.
- stage  out  clog2(DEPTH+1)  number of codes matched so far.
- fail_value  out  WIDTH  settled value that caused the failure.
- fail_code  out  2  0 none, 1 mismatch, 2 config error, 3 timeout.

Behaviour:
Reset (resetb low, asynchronous):
- All outputs 0, all table entries 0, state IDLE, synchronizer and counters 0.

Input filtering:
- checkbits passes through a 2-flop synchronizer; its output is s.
- A hold counter counts consecutive cycles with s unchanged.
- A settle event fires exactly once per new value, in the cycle where the hold reaches STABLE_CYCLES.
- Latency from a stable input change to the registered status update is 2 + STABLE_CYCLES cycles.

Table writes:
- A write takes effect on the edge where wr_en is high.
- Writes are ignored while ARMED.

States: IDLE, ARMED, DONE_PASS, DONE_FAIL, DONE_TMO.
- start from IDLE or any DONE state with 1 <= num_stages <= DEPTH:
  - go to ARMED, stage = 0, timer = 0;
  - clear pass, fail, timeout, started, fail_value and fail_code;
  - latch num_stages, strict and timeout_cycles.
- start with num_stages = 0 or num_stages > DEPTH: go to DONE_FAIL, fail_code = 2.
- start while ARMED is ignored.
- In ARMED, on a settle event with value v:
  - v == exp[stage]: stage increments, timer = 0; if stage == 0, set started; if the new stage == num_stages, go to DONE_PASS and set pass.
  - v == exp[stage-1] (stage > 0): ignored.
  - any other v: if strict, go to DONE_FAIL, fail_code = 1, fail_value = v; otherwise ignored.
- Value already settled at arm time: it is evaluated in the first ARMED cycle. If it matches exp[0] it counts as a match; otherwise it is ignored in both modes.
- Timer: increments every ARMED cycle. When it equals timeout_cycles (non-zero), go to DONE_TMO, timeout = 1, fail_code = 3.

Priorities and held state:
- A match and a timeout in the same cycle: the match wins.
- clear returns any state to IDLE and zeroes status outputs; the table is kept.
- clear and start in the same cycle: clear wins.
- DONE states hold their outputs until clear or start.
- busy = (state == ARMED).
- Reset asserted mid-run aborts the run immediately.

Decomposition:
- Package checkpoint_pkg:
  - state enum (IDLE, ARMED, DONE_PASS, DONE_FAIL, DONE_TMO);
  - fail_code constants FC_NONE, FC_MISMATCH, FC_CFG, FC_TMO.
- Sub-module checkbits_settle:
  - contains the synchronizer, hold counter and settle pulse;
  - parameters WIDTH and STABLE_CYCLES;
  - outputs: settled value and a settle_evt pulse.
- The top level holds the table, FSM and timer.

Test Plan:
1. Basic pass: write exp[0]=AB60, exp[1]=AB61, num_stages=2, strict=1, timeout=0, start; drive 0000, then AB60, then AB61, each held 10 cycles. Expect started 4 cycles after AB60 (STABLE_CYCLES=2), pass 4 cycles after AB61, stage=2, fail=0.
2. Glitch filtering: with setup 1 armed, a 1-cycle AB60 pulse gives no event; a 1-cycle 1234 pulse in strict mode gives no fail; a held AB60 then sets started.
3. Strict mismatch: after AB60, drive 5555 held. Expect fail=1, fail_code=1, fail_value=5555, stage=1. The same stimulus with strict=0 leaves busy=1 and no fail.
4. Timeout: timeout_cycles=50; after AB60, hold it. Expect timeout=1, fail_code=3 exactly 50 cycles after the AB60 match. A match landing on the expiry cycle instead advances stage.
5. Configuration and control: start with num_stages=0 gives fail_code=2 with no ARMED cycle. wr_en while ARMED leaves the table unchanged. clear and start together leave the block in IDLE.
6. Reset mid-run: resetb low while stage=1 clears all outputs and the table asynchronously. Re-program, then a run with num_stages=4 (four distinct codes) passes.
